// File: rtl/add_operand_sequencer_pkg.sv
// Shared constants and FSM encoding for the serial-adder operand sequencer.
package add_operand_sequencer_pkg;

    localparam int OP_W = 4;

    localparam logic [1:0] P_SEQ_NONE   = 2'd0;
    localparam logic [1:0] P_SEQ_FIRST  = 2'd1;
    localparam logic [1:0] P_SEQ_SECOND = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_P1  = 3'd1,
        ST_SEND_P2  = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_OUT      = 3'd4
    } state_t;

endpackage

// File: rtl/add_operand_sequencer_operand_pair_fifo.sv
// Small show-ahead FIFO of {a,b} operand pairs; head entry is visible before pop.
module operand_pair_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    // Storage needs no reset: contents are only observed through the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/add_operand_sequencer.sv
// Feeds queued operand pairs to a serial adder over p/p_seq, collects s,
// and hands results (or a timeout error) to a valid/ready consumer.
module add_operand_sequencer
    import add_operand_sequencer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int RES_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [OP_W-1:0] i_in_a,
    input  logic [OP_W-1:0] i_in_b,
    output logic [OP_W-1:0] o_p,
    output logic [1:0]      o_p_seq,
    input  logic            i_res_valid,
    input  logic [OP_W-1:0] i_s,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [OP_W-1:0] o_out_sum,
    output logic            o_out_err,
    output logic            o_busy
);

    localparam int TMO_W = $clog2(RES_TIMEOUT);

    state_t              r_state;
    state_t              w_state_next;
    logic [OP_W-1:0]     r_b;
    logic [OP_W-1:0]     r_p;
    logic [1:0]          r_p_seq;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [OP_W-1:0]     r_out_sum;
    logic                r_out_err;
    logic                w_fifo_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [2*OP_W-1:0]   w_fifo_data;
    logic                w_capture;
    logic                w_timeout;

    operand_pair_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * OP_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (i_in_valid),
        .i_push_data ({i_in_a, i_in_b}),
        .i_pop       (w_fifo_pop),
        .o_pop_data  (w_fifo_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_fifo_pop   = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop   = 1'b1;
                    w_state_next = ST_SEND_P1;
                end
            end
            ST_SEND_P1: w_state_next = ST_SEND_P2;
            ST_SEND_P2: w_state_next = ST_WAIT_RES;
            ST_WAIT_RES: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (i_res_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_OUT;
                end else if (r_tmo_cnt == TMO_W'(RES_TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (i_out_ready) begin
                    if (!w_fifo_empty) begin
                        w_fifo_pop   = 1'b1;
                        w_state_next = ST_SEND_P1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_b       <= '0;
            r_p       <= '0;
            r_p_seq   <= P_SEQ_NONE;
            r_tmo_cnt <= '0;
            r_out_sum <= '0;
            r_out_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_fifo_pop) begin
                r_b <= w_fifo_data[OP_W-1:0];
            end
            // p/p_seq follow the next state so the adder sees them aligned with the state.
            case (w_state_next)
                ST_SEND_P1: begin
                    r_p     <= w_fifo_data[2*OP_W-1:OP_W];
                    r_p_seq <= P_SEQ_FIRST;
                end
                ST_SEND_P2: begin
                    r_p     <= r_b;
                    r_p_seq <= P_SEQ_SECOND;
                end
                default: r_p_seq <= P_SEQ_NONE;
            endcase
            if (r_state == ST_SEND_P2) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_WAIT_RES) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (w_capture) begin
                r_out_sum <= i_s;
                r_out_err <= 1'b0;
            end else if (w_timeout) begin
                r_out_sum <= '0;
                r_out_err <= 1'b1;
            end
        end
    end

    assign o_in_ready  = !w_fifo_full;
    assign o_p         = r_p;
    assign o_p_seq     = r_p_seq;
    assign o_out_valid = (r_state == ST_OUT);
    assign o_out_sum   = r_out_sum;
    assign o_out_err   = r_out_err;
    assign o_busy      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_add_operand_sequencer.sv
// Randomised and directed bench for add_operand_sequencer with a serial-adder
// model and a transaction-level scoreboard checked every cycle.
module tb_add_operand_sequencer;

    localparam int DEPTH = 4;
    localparam int T     = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       res_valid = 1'b0;
    logic [3:0] s = '0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic [3:0] p;
    logic [1:0] p_seq;
    logic       out_valid;
    logic [3:0] out_sum;
    logic       out_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int adder_lat = 1;   // 0 = adder never answers
    bit junk_en = 1'b0;  // spurious res_valid outside the waiting window

    add_operand_sequencer #(.DEPTH(DEPTH), .RES_TIMEOUT(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .o_p         (p),
        .o_p_seq     (p_seq),
        .i_res_valid (res_valid),
        .i_s         (s),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_sum   (out_sum),
        .o_out_err   (out_err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial adder: latches a on p_seq=1, answers a+b after adder_lat cycles.
    initial begin : adder
        logic [3:0] a_l;
        logic [3:0] sum_l;
        int del;
        a_l = '0; sum_l = '0; del = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                del = 0;
            end else begin
                if (p_seq == 2'd1) a_l = p;
                if (p_seq == 2'd2 && adder_lat != 0) begin
                    sum_l = 4'((int'(a_l) + int'(p)) % 16);
                    del = adder_lat;
                end
            end
            @(posedge clk); #1;
            if (!rst) begin
                res_valid = 1'b0;
                del = 0;
            end else if (del == 1) begin
                res_valid = 1'b1;
                s = sum_l;
                del = 0;
            end else begin
                if (del > 1) del--;
                res_valid = junk_en && (p_seq != 2'd0 || out_valid || !busy);
                s = 4'($urandom_range(0, 15));
            end
        end
    end

    // Transaction-level reference: queue of accepted pairs plus one in-flight op.
    typedef struct { logic [3:0] a; logic [3:0] b; } pair_t;
    pair_t pending[$];

    initial begin : monitor
        bit have_cur, pop_prev, pop_now, exp_ov, ready_now, exp_err;
        int prev_e, e, out_at;
        logic [3:0] cur_a, cur_b, last_p, exp_sum;
        pair_t pr;
        have_cur = 0; pop_prev = 0; prev_e = 0; out_at = 0;
        cur_a = '0; cur_b = '0; last_p = '0; exp_sum = '0; exp_err = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                pending.delete();
                have_cur = 0; pop_prev = 0; prev_e = 0; last_p = '0;
                check("rst_p_seq", int'(p_seq), 0);
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_in_ready", int'(in_ready), 1);
                check("rst_out_sum", int'(out_sum), 0);
                check("rst_out_err", int'(out_err), 0);
                check("rst_p", int'(p), 0);
            end else begin
                e = pop_prev ? 1 : (prev_e == 1 ? 2 : 0);
                check("p_seq", int'(p_seq), e);
                if (e == 1) begin
                    check("p_first", int'(p), int'(cur_a));
                    last_p = cur_a;
                end else if (e == 2) begin
                    check("p_second", int'(p), int'(cur_b));
                    last_p = cur_b;
                    out_at  = cyc + 1 + ((adder_lat == 0) ? T : adder_lat);
                    exp_sum = (adder_lat == 0) ? 4'd0 : 4'((int'(cur_a) + int'(cur_b)) % 16);
                    exp_err = (adder_lat == 0);
                end else begin
                    check("p_hold", int'(p), int'(last_p));
                end
                exp_ov = have_cur && (cyc >= out_at);
                check("out_valid", int'(out_valid), int'(exp_ov));
                if (exp_ov) begin
                    check("out_sum", int'(out_sum), int'(exp_sum));
                    check("out_err", int'(out_err), int'(exp_err));
                end
                ready_now = (pending.size() < DEPTH);
                check("in_ready", int'(in_ready), int'(ready_now));
                check("busy", int'(busy), int'(have_cur || pending.size() != 0));
                if (exp_ov && out_ready) have_cur = 0;
                pop_now = 0;
                if (!have_cur && pending.size() > 0) begin
                    pr = pending.pop_front();
                    cur_a = pr.a; cur_b = pr.b;
                    have_cur = 1; pop_now = 1;
                    out_at = 32'h7fff_ffff;
                end
                if (in_valid && ready_now) begin
                    pr.a = in_a; pr.b = in_b;
                    pending.push_back(pr);
                end
                pop_prev = pop_now;
                prev_e = e;
            end
        end
    end

    task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b;
        @(negedge clk); #1;
        while (!in_ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 200) check("push_bound", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("push a=%0d b=%0d at cycle %0d", a, b, cyc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk); #1;
        while (busy && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 400) check("idle_bound", 0, 1);
    endtask

    task automatic wait_out(output int c);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!out_valid && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) check("out_bound", 0, 1);
        c = cyc;
        $display("result sum=%0d err=%0d at cycle %0d", out_sum, out_err, cyc);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c2, co, fires, k, n;
        int times[5];
        int sums[5];
        int exp_sums[5];
        exp_sums = '{1, 4, 7, 10, 13};
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Single op 2+3 with a 1-cycle adder.
        adder_lat = 1; out_ready = 1'b1;
        push_pair(4'd2, 4'd3);
        @(negedge clk); #1; check("d1_seq0", int'(p_seq), 0);
        @(negedge clk); #1; check("d1_seq1", int'(p_seq), 1); check("d1_p1", int'(p), 2);
        @(negedge clk); #1; check("d1_seq2", int'(p_seq), 2); check("d1_p2", int'(p), 3);
        @(negedge clk); #1; check("d1_seq3", int'(p_seq), 0); check("d1_ov3", int'(out_valid), 0);
        @(negedge clk); #1; check("d1_ov4", int'(out_valid), 1);
        check("d1_sum", int'(out_sum), 5); check("d1_err", int'(out_err), 0);
        wait_idle();

        // 9+8 wraps modulo 16 in the adder.
        push_pair(4'd9, 4'd8);
        wait_out(co);
        check("d2_sum", int'(out_sum), 1); check("d2_err", int'(out_err), 0);
        wait_idle();

        // Burst of 5 back-to-back pushes fills the DEPTH=4 FIFO.
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = 4'(i + 1); in_b = 4'(2 * i);
            n = 0;
            @(negedge clk); #1;
            while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        fires = 0;
        for (k = 0; k < 60 && fires < 5; k++) begin
            @(negedge clk); #1;
            if (k == 0) check("burst_full", int'(in_ready), 0);
            if (out_valid) begin
                times[fires] = cyc; sums[fires] = int'(out_sum); fires++;
                $display("burst result sum=%0d at cycle %0d", out_sum, cyc);
            end
        end
        check("burst_count", fires, 5);
        for (int i = 0; i < 5; i++) begin
            check("burst_sum", sums[i], exp_sums[i]);
            if (i > 0) check("burst_period", times[i] - times[i-1], 4);
        end
        wait_idle();

        // Adder never answers: timeout after exactly T waiting cycles.
        adder_lat = 0;
        push_pair(4'd7, 4'd7);
        n = 0;
        @(negedge clk); #1;
        while (p_seq != 2'd2 && n < 20) begin @(negedge clk); #1; n++; end
        c2 = cyc;
        wait_out(co);
        check("tmo_delay", co - c2, T + 1);
        check("tmo_err", int'(out_err), 1); check("tmo_sum", int'(out_sum), 0);
        wait_idle();
        adder_lat = 1;
        push_pair(4'd4, 4'd5);
        wait_out(co);
        check("post_tmo_sum", int'(out_sum), 9); check("post_tmo_err", int'(out_err), 0);
        wait_idle();

        // Consumer stalls with two pairs queued.
        @(posedge clk); #1; out_ready = 1'b0;
        push_pair(4'd1, 4'd2);
        push_pair(4'd3, 4'd4);
        wait_out(co);
        check("hold_sum0", int'(out_sum), 3);
        repeat (10) begin
            @(negedge clk); #1;
            check("hold_ov", int'(out_valid), 1);
            check("hold_sum", int'(out_sum), 3);
            check("hold_seq", int'(p_seq), 0);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk); #1; check("rel_ov", int'(out_valid), 1);
        @(negedge clk); #1; check("rel_seq", int'(p_seq), 1); check("rel_p", int'(p), 3);
        wait_idle();

        // Reset asserted while the first of two queued ops is in SEND_P2.
        push_pair(4'd5, 4'd6);
        push_pair(4'd1, 4'd1);
        n = 0;
        while (p_seq != 2'd2 && n < 20) begin @(negedge clk); #1; n++; end
        check("rst_mid_seq2", int'(p_seq), 2);
        #1 rst = 1'b0;
        #1;
        check("rstm_p_seq", int'(p_seq), 0);
        check("rstm_ov", int'(out_valid), 0);
        check("rstm_busy", int'(busy), 0);
        check("rstm_ready", int'(in_ready), 1);
        @(negedge clk); #2 rst = 1'b1;
        push_pair(4'd6, 4'd7);
        wait_out(co);
        check("after_rst_sum", int'(out_sum), 13);
        wait_idle();

        // Random traffic across adder latencies, timeouts and spurious res_valid.
        for (int ph = 0; ph < 6; ph++) begin
            adder_lat = ph % 3;
            junk_en = (ph >= 3);
            repeat (250) begin
                @(posedge clk); #1;
                in_valid  = 1'($urandom_range(0, 1));
                in_a      = 4'($urandom_range(0, 15));
                in_b      = 4'($urandom_range(0, 15));
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b1;
            wait_idle();
            $display("random phase %0d lat=%0d junk=%0d done at cycle %0d", ph, adder_lat, junk_en, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
